// File: rtl/scp_light_pkg.sv
// Shared types and defaults for the scp traffic-light sequencer stages.
package scp_light_pkg;

  // Colour phase encoding; the fourth code is unused and recovers to green.
  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_RED    = 2'd2
  } phase_t;

  localparam int DEF_GREEN_LEN  = 35;
  localparam int DEF_YELLOW_LEN = 5;
  localparam int DEF_RED_LEN    = 20;
  localparam int DEF_TICK_DIV   = 1;
  localparam int DEF_TIMER_W    = 6;
  localparam int PHASE_CNT_W    = 8;

  // Normal colour rotation G -> Y -> R -> G; anything unexpected goes to green.
  function automatic phase_t next_phase(input phase_t ph);
    phase_t nxt;
    case (ph)
      PH_GREEN:  nxt = PH_YELLOW;
      PH_YELLOW: nxt = PH_RED;
      default:   nxt = PH_GREEN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/scp_tick_prescaler.sv
// Tick prescaler: emits a one-cycle tick every TICK_DIV enabled clock cycles.
// clr zeroes the count and suppresses the tick; hold freezes the count.
module scp_tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic hold,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Next count and tick: clr beats hold, tick fires on the wrapping cycle.
  always_comb begin
    cnt_next = cnt_reg;
    tick     = 1'b0;
    if (clr) begin
      cnt_next = '0;
    end else if (!hold) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next = '0;
        tick     = 1'b1;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/scp_light_sequencer.sv
// Traffic-light sequencer feeding scp_079: cycles green/yellow/red with
// per-colour lengths in ticks, a saturating in-colour timer, hold, a
// downstream timer clear and an emergency force-to-red override.
module scp_light_sequencer
  import scp_light_pkg::*;
#(
  parameter int GREEN_LEN  = DEF_GREEN_LEN,
  parameter int YELLOW_LEN = DEF_YELLOW_LEN,
  parameter int RED_LEN    = DEF_RED_LEN,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int TIMER_W    = DEF_TIMER_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               timer_clr,
  input  logic               hold,
  input  logic               force_red,
  output logic               green,
  output logic               yellow,
  output logic               red,
  output logic [TIMER_W-1:0] timer,
  output logic               phase_done
);

  localparam logic [PHASE_CNT_W-1:0] GREEN_LAST  = PHASE_CNT_W'(GREEN_LEN - 1);
  localparam logic [PHASE_CNT_W-1:0] YELLOW_LAST = PHASE_CNT_W'(YELLOW_LEN - 1);
  localparam logic [PHASE_CNT_W-1:0] RED_LAST    = PHASE_CNT_W'(RED_LEN - 1);
  localparam logic [TIMER_W-1:0]     TIMER_MAX   = '1;

  phase_t                 phase_reg, phase_next;
  logic [PHASE_CNT_W-1:0] phase_cnt_reg, phase_cnt_next;
  logic [TIMER_W-1:0]     timer_reg, timer_next;
  logic                   phase_done_reg, phase_done_next;
  logic [2:0]             colour_reg, colour_next;  // bit index = phase code
  logic [PHASE_CNT_W-1:0] phase_last;
  logic                   phase_legal;
  logic                   tick;

  // Prescaler is frozen by hold and zeroed by the emergency override.
  scp_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .hold    (hold),
    .clr     (force_red),
    .tick    (tick)
  );

  // Last phase_cnt value of the current colour, and legality of the phase code.
  always_comb begin
    phase_last  = GREEN_LAST;
    phase_legal = 1'b1;
    case (phase_reg)
      PH_GREEN:  phase_last = GREEN_LAST;
      PH_YELLOW: phase_last = YELLOW_LAST;
      PH_RED:    phase_last = RED_LAST;
      default:   phase_legal = 1'b0;
    endcase
  end

  // Next-state: force_red, then hold, then timer_clr, then the tick.
  always_comb begin
    phase_next      = phase_reg;
    phase_cnt_next  = phase_cnt_reg;
    timer_next      = timer_reg;
    phase_done_next = 1'b0;
    if (force_red) begin
      // Red is pinned at its start so a full red phase follows the release.
      phase_cnt_next = '0;
      timer_next     = '0;
      if (phase_reg != PH_RED) begin
        phase_next      = PH_RED;
        phase_done_next = 1'b1;
      end
    end else if (!phase_legal) begin
      phase_next     = PH_GREEN;
      phase_cnt_next = '0;
      timer_next     = '0;
    end else if (!hold) begin
      if (tick) begin
        if (phase_cnt_reg == phase_last) begin
          phase_next      = next_phase(phase_reg);
          phase_cnt_next  = '0;
          timer_next      = '0;
          phase_done_next = 1'b1;
        end else begin
          phase_cnt_next = phase_cnt_reg + PHASE_CNT_W'(1);
          if (timer_reg != TIMER_MAX) begin
            timer_next = timer_reg + TIMER_W'(1);
          end
        end
      end
      // The clear only touches the timer, so phase timing is unaffected.
      if (timer_clr) begin
        timer_next = '0;
      end
    end
  end

  // One-hot colour decode of the next phase, registered below.
  for (genvar gi = 0; gi < 3; gi++) begin : g_colour
    assign colour_next[gi] = (phase_next == phase_t'(gi));
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_reg      <= PH_GREEN;
      phase_cnt_reg  <= '0;
      timer_reg      <= '0;
      phase_done_reg <= 1'b0;
      colour_reg     <= 3'b001;
    end else begin
      phase_reg      <= phase_next;
      phase_cnt_reg  <= phase_cnt_next;
      timer_reg      <= timer_next;
      phase_done_reg <= phase_done_next;
      colour_reg     <= colour_next;
    end
  end

  assign green      = colour_reg[PH_GREEN];
  assign yellow     = colour_reg[PH_YELLOW];
  assign red        = colour_reg[PH_RED];
  assign timer      = timer_reg;
  assign phase_done = phase_done_reg;

endmodule

// File: tb/tb_scp_light_sequencer.sv
// Directed bench for scp_light_sequencer: default instance (A), TICK_DIV=4
// instance (B) and RED_LEN=100 instance (C) sharing one clock.
module tb_scp_light_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: defaults, all controls driven.
  logic rst_a = 1'b0, clr_a = 1'b0, hold_a = 1'b0, force_a = 1'b0;
  logic g_a, y_a, r_a, done_a;
  logic [5:0] timer_a;
  // Instances B and C: free-running, own resets.
  logic rst_b = 1'b0, rst_c = 1'b0, quiet = 1'b0;
  logic g_b, y_b, r_b, done_b, g_c, y_c, r_c, done_c;
  logic [5:0] timer_b, timer_c;

  wire [9:0] obs_a = {g_a, y_a, r_a, timer_a, done_a};
  wire [9:0] obs_b = {g_b, y_b, r_b, timer_b, done_b};
  wire [9:0] obs_c = {g_c, y_c, r_c, timer_c, done_c};

  scp_light_sequencer u_a (
    .clock(clk), .reset_n(rst_a), .timer_clr(clr_a), .hold(hold_a), .force_red(force_a),
    .green(g_a), .yellow(y_a), .red(r_a), .timer(timer_a), .phase_done(done_a)
  );

  scp_light_sequencer #(.TICK_DIV(4)) u_b (
    .clock(clk), .reset_n(rst_b), .timer_clr(quiet), .hold(quiet), .force_red(quiet),
    .green(g_b), .yellow(y_b), .red(r_b), .timer(timer_b), .phase_done(done_b)
  );

  scp_light_sequencer #(.RED_LEN(100)) u_c (
    .clock(clk), .reset_n(rst_c), .timer_clr(quiet), .hold(quiet), .force_red(quiet),
    .green(g_c), .yellow(y_c), .red(r_c), .timer(timer_c), .phase_done(done_c)
  );

  // Expected {g,y,r,timer,done} at position p ticks into a 35/5/20 light cycle.
  function automatic logic [9:0] exp_vec(input int p, input logic d);
    if (p < 35)      return {3'b100, 6'(p), d};
    else if (p < 40) return {3'b010, 6'(p - 35), d};
    else             return {3'b001, 6'(p - 40), d};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [9:0] e;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    step(3);
    e = {3'b100, 6'd0, 1'b0};
    checks++; if (obs_a !== e) begin errors++; $display("FAIL reset_a: got %b expected %b", obs_a, e); end
    checks++; if (obs_b !== e) begin errors++; $display("FAIL reset_b: got %b expected %b", obs_b, e); end
    checks++; if (obs_c !== e) begin errors++; $display("FAIL reset_c: got %b expected %b", obs_c, e); end
    rst_a = 1'b1;
  endtask

  task automatic test_free_run();
    logic [9:0] e;
    for (int c = 0; c < 60; c++) begin
      e = exp_vec(c, (c == 35 || c == 40));
      checks++;
      if (obs_a !== e) begin errors++; $display("FAIL free_run c=%0d: got %b expected %b", c, obs_a, e); end
      step(1);
    end
    e = exp_vec(0, 1'b1);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL free_run_wrap: got %b expected %b", obs_a, e); end
  endtask

  task automatic test_tick_div();
    logic [9:0] e;
    int u, p;
    rst_a = 1'b0;  // park A while B runs
    rst_b = 1'b1;
    for (int c = 0; c < 720; c++) begin
      u = c / 4;
      p = u % 60;
      e = exp_vec(p, (c % 4 == 0) && (u > 0) && (p == 0 || p == 35 || p == 40));
      checks++;
      if (obs_b !== e) begin errors++; $display("FAIL tick_div c=%0d: got %b expected %b", c, obs_b, e); end
      step(1);
    end
  endtask

  task automatic test_force_red();
    logic [9:0] e;
    rst_a = 1'b1;
    step(10);
    e = exp_vec(10, 1'b0);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL force_pre: got %b expected %b", obs_a, e); end
    force_a = 1'b1; step(1); force_a = 1'b0;
    e = exp_vec(40, 1'b1);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL force_pulse: got %b expected %b", obs_a, e); end
    for (int k = 1; k < 20; k++) begin
      step(1);
      e = exp_vec(40 + k, 1'b0);
      checks++; if (obs_a !== e) begin errors++; $display("FAIL force_red_run k=%0d: got %b expected %b", k, obs_a, e); end
    end
    step(1);
    e = exp_vec(0, 1'b1);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL force_back_green: got %b expected %b", obs_a, e); end
    force_a = 1'b1; step(1);
    e = exp_vec(40, 1'b1);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL force_hold_entry: got %b expected %b", obs_a, e); end
    for (int k = 1; k < 30; k++) begin
      step(1);
      e = exp_vec(40, 1'b0);
      checks++; if (obs_a !== e) begin errors++; $display("FAIL force_held k=%0d: got %b expected %b", k, obs_a, e); end
    end
    force_a = 1'b0;
    for (int k = 1; k < 20; k++) begin
      step(1);
      e = exp_vec(40 + k, 1'b0);
      checks++; if (obs_a !== e) begin errors++; $display("FAIL force_release k=%0d: got %b expected %b", k, obs_a, e); end
    end
    step(1);
    e = exp_vec(0, 1'b1);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL force_release_end: got %b expected %b", obs_a, e); end
  endtask

  task automatic test_hold();
    logic [9:0] e;
    step(37);
    e = exp_vec(37, 1'b0);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL hold_pre: got %b expected %b", obs_a, e); end
    hold_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      clr_a = (i == 3);  // a clear during hold must be ignored
      step(1);
      checks++; if (obs_a !== e) begin errors++; $display("FAIL hold_frozen i=%0d: got %b expected %b", i, obs_a, e); end
    end
    hold_a = 1'b0; clr_a = 1'b0;
    step(1);
    e = exp_vec(38, 1'b0);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL hold_resume1: got %b expected %b", obs_a, e); end
    step(1);
    e = exp_vec(39, 1'b0);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL hold_resume2: got %b expected %b", obs_a, e); end
    step(1);
    e = exp_vec(40, 1'b1);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL hold_to_red: got %b expected %b", obs_a, e); end
  endtask

  task automatic test_timer_clr();
    logic [9:0] e;
    step(20);
    e = exp_vec(0, 1'b1);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL clr_green_start: got %b expected %b", obs_a, e); end
    step(20);
    e = exp_vec(20, 1'b0);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL clr_pre: got %b expected %b", obs_a, e); end
    clr_a = 1'b1; step(1); clr_a = 1'b0;
    e = {3'b100, 6'd0, 1'b0};
    checks++; if (obs_a !== e) begin errors++; $display("FAIL clr_zero: got %b expected %b", obs_a, e); end
    for (int k = 1; k <= 13; k++) begin
      step(1);
      e = {3'b100, 6'(k), 1'b0};
      checks++; if (obs_a !== e) begin errors++; $display("FAIL clr_count k=%0d: got %b expected %b", k, obs_a, e); end
    end
    step(1);
    e = exp_vec(35, 1'b1);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL clr_yellow_on_time: got %b expected %b", obs_a, e); end
    step(4);
    e = exp_vec(39, 1'b0);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL clr_yellow_last: got %b expected %b", obs_a, e); end
    clr_a = 1'b1; step(1); clr_a = 1'b0;
    e = exp_vec(40, 1'b1);
    checks++; if (obs_a !== e) begin errors++; $display("FAIL clr_with_expiry: got %b expected %b", obs_a, e); end
  endtask

  task automatic test_saturation();
    logic [9:0] e;
    rst_c = 1'b1;
    step(40);
    for (int k = 0; k < 100; k++) begin
      e = {3'b001, 6'((k > 63) ? 63 : k), (k == 0)};
      checks++; if (obs_c !== e) begin errors++; $display("FAIL sat_red k=%0d: got %b expected %b", k, obs_c, e); end
      step(1);
    end
    e = {3'b100, 6'd0, 1'b1};
    checks++; if (obs_c !== e) begin errors++; $display("FAIL sat_to_green: got %b expected %b", obs_c, e); end
    step(50);
    e = {3'b001, 6'd10, 1'b0};
    checks++; if (obs_c !== e) begin errors++; $display("FAIL sat_mid_red: got %b expected %b", obs_c, e); end
    #2 rst_c = 1'b0;
    #1;
    e = {3'b100, 6'd0, 1'b0};
    checks++; if (obs_c !== e) begin errors++; $display("FAIL async_reset: got %b expected %b", obs_c, e); end
    step(1);
    rst_c = 1'b1;
    step(1);
    e = {3'b100, 6'd1, 1'b0};
    checks++; if (obs_c !== e) begin errors++; $display("FAIL reset_first_tick: got %b expected %b", obs_c, e); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_tick_div();
    test_force_red();
    test_hold();
    test_timer_clr();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
